// File: rtl/maccum_state_arbiter.sv
// rtl/maccum_state_arbiter.sv - two-requester round-robin state arbiter with tag-routed accumulator returns
module maccum_state_arbiter #(
    parameter int NP    = 4,
    parameter int NC    = 4,
    parameter int WF    = 4,
    parameter int DEPTH = 4
) (
    input  logic                              iCLK,
    input  logic                              iRST,
    input  logic                              iValid_RQ_State0,
    output logic                              oReady_RQ_State0,
    input  logic [NP*WF-1:0]                  iData_RQ_State0,
    input  logic                              iValid_RQ_State1,
    output logic                              oReady_RQ_State1,
    input  logic [NP*WF-1:0]                  iData_RQ_State1,
    output logic                              oValid_MA_State,
    input  logic                              iReady_MA_State,
    output logic [NP*WF-1:0]                  oData_MA_State,
    input  logic                              iValid_MA_Accum,
    output logic                              oReady_MA_Accum,
    input  logic [NC*($clog2(NP)+WF)-1:0]     iData_MA_Accum,
    output logic                              oValid_RQ_Accum0,
    input  logic                              iReady_RQ_Accum0,
    output logic [NC*($clog2(NP)+WF)-1:0]     oData_RQ_Accum0,
    output logic                              oValid_RQ_Accum1,
    input  logic                              iReady_RQ_Accum1,
    output logic [NC*($clog2(NP)+WF)-1:0]     oData_RQ_Accum1,
    output logic [$clog2(DEPTH+1)-1:0]        oOutstanding
);

    localparam int SW = NP * WF;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic          state_valid_q, state_valid_d;
    logic [SW-1:0] state_data_q, state_data_d;
    logic          pri_q, pri_d;
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] count_q, count_d;

    logic load, eligible, gnt0, gnt1, push, pop, empty, head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        load     = !state_valid_q || iReady_MA_State;
        // occupancy is the registered count, so a same-cycle pop cannot make room
        eligible = load && (count_q < OW'(DEPTH)) && !iRST;
        gnt0     = iValid_RQ_State0 && (!iValid_RQ_State1 || !pri_q);
        gnt1     = iValid_RQ_State1 && (!iValid_RQ_State0 || pri_q);
        push     = eligible && (gnt0 || gnt1);

        oReady_RQ_State0 = eligible && gnt0;
        oReady_RQ_State1 = eligible && gnt1;

        empty = (count_q == '0);
        head  = tag_q[rd_ptr_q];

        oValid_RQ_Accum0 = iValid_MA_Accum && !empty && !head;
        oValid_RQ_Accum1 = iValid_MA_Accum && !empty && head;
        oData_RQ_Accum0  = iData_MA_Accum;
        oData_RQ_Accum1  = iData_MA_Accum;
        oReady_MA_Accum  = !empty && (head ? iReady_RQ_Accum1 : iReady_RQ_Accum0);
        pop              = iValid_MA_Accum && oReady_MA_Accum;

        state_valid_d = state_valid_q;
        state_data_d  = state_data_q;
        pri_d         = pri_q;
        tag_d         = tag_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (push) begin
            state_valid_d  = 1'b1;
            state_data_d   = gnt1 ? iData_RQ_State1 : iData_RQ_State0;
            pri_d          = gnt0;
            tag_d[wr_ptr_q] = gnt1;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end else if (iReady_MA_State) begin
            state_valid_d = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        count_d = count_q + OW'(push) - OW'(pop);

        oValid_MA_State = state_valid_q;
        oData_MA_State  = state_data_q;
        oOutstanding    = count_q;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_valid_q <= 1'b0;
            state_data_q  <= '0;
            pri_q         <= 1'b0;
            tag_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_valid_q <= state_valid_d;
            state_data_q  <= state_data_d;
            pri_q         <= pri_d;
            tag_q         <= tag_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule
